// File: rtl/pulse_sched_if.sv
// Requester-side bundle of the pulse scheduler: level requests in, ownership and strobes out.
interface pulse_sched_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] pulse_out;
    logic               timeout;
    logic               busy;

    modport master (output req, input grant, input pulse_out, input timeout, input busy);
    modport slave  (input req, output grant, output pulse_out, output timeout, output busy);
endinterface

// File: rtl/pulse_sched.sv
// Round-robin scheduler sharing one random-pulse generator between NUM_REQ requesters:
// re-arms the generator, forwards the next pulse rise to the owner, then holds off.
module pulse_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned HOLDOFF_W = 8,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic                 pulse_in,
    output logic                 gen_enable,
    pulse_sched_if.slave         bus
);
    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ARM, WAIT, DELIVER, HOLD} state_t;

    state_t               state, nxt_state;
    logic [PW-1:0]        rr_ptr, nxt_rr;
    logic [PW-1:0]        owner, nxt_owner, owner_inc;
    logic [PW-1:0]        pick_idx, cand;
    logic                 pick_found;
    logic                 pulse_q, rise;
    logic [TW-1:0]        timer, nxt_timer;
    logic [HOLDOFF_W-1:0] hold_cnt, nxt_hold;
    logic [NUM_REQ-1:0]   grant_q, pulse_out_q, nxt_grant, nxt_pulse_out;
    logic                 timeout_q, busy_q;
    logic                 nxt_gen_enable, nxt_timeout, nxt_busy;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    assign rise      = pulse_in & ~pulse_q;
    assign owner_inc = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);

    // First pending request at or after rr_ptr, scanning with wrap-around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            timer       <= '0;
            hold_cnt    <= '0;
            pulse_q     <= 1'b0;
            gen_enable  <= 1'b0;
            grant_q     <= '0;
            pulse_out_q <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= nxt_state;
            rr_ptr      <= nxt_rr;
            owner       <= nxt_owner;
            timer       <= nxt_timer;
            hold_cnt    <= nxt_hold;
            pulse_q     <= pulse_in;
            gen_enable  <= nxt_gen_enable;
            grant_q     <= nxt_grant;
            pulse_out_q <= nxt_pulse_out;
            timeout_q   <= nxt_timeout;
            busy_q      <= nxt_busy;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_rr    = rr_ptr;
        nxt_owner = owner;
        nxt_timer = timer;
        nxt_hold  = hold_cnt;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    nxt_owner = pick_idx;
                    nxt_state = ARM;
                end
            end
            ARM: begin
                nxt_timer = '0;
                nxt_state = WAIT;
            end
            WAIT: begin
                if (!bus.req[owner]) begin
                    nxt_rr    = owner_inc;
                    nxt_state = IDLE;
                end else if (rise) begin
                    nxt_state = DELIVER;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    nxt_rr    = owner_inc;
                    nxt_hold  = holdoff;
                    nxt_state = HOLD;
                end else begin
                    nxt_timer = timer + TW'(1);
                end
            end
            DELIVER: begin
                nxt_rr    = owner_inc;
                nxt_hold  = holdoff;
                nxt_state = (holdoff != '0) ? HOLD : IDLE;
            end
            HOLD: begin
                // A zero hold-off after a timeout still costs one HOLD cycle.
                if (hold_cnt <= HOLDOFF_W'(1)) nxt_state = IDLE;
                else nxt_hold = hold_cnt - HOLDOFF_W'(1);
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        nxt_gen_enable = (nxt_state == ARM);
        nxt_grant      = '0;
        if (nxt_state inside {ARM, WAIT, DELIVER}) nxt_grant = onehot(nxt_owner);
        nxt_pulse_out  = (nxt_state == DELIVER) ? onehot(nxt_owner) : '0;
        nxt_timeout    = (state == WAIT) && (nxt_state == HOLD);
        nxt_busy       = (nxt_state != IDLE);
    end

    assign bus.grant     = grant_q;
    assign bus.pulse_out = pulse_out_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pulse_sched.sv
// Self-checking bench for pulse_sched: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural reference model.
module tb_pulse_sched;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned HOLDOFF_W = 8;
    localparam int unsigned TIMEOUT   = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [HOLDOFF_W-1:0] holdoff;
    logic                 pulse_in;
    logic                 gen_enable;

    pulse_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    pulse_sched #(.NUM_REQ(NUM_REQ), .HOLDOFF_W(HOLDOFF_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .holdoff    (holdoff),
        .pulse_in   (pulse_in),
        .gen_enable (gen_enable),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // Reference model: who owns the generator and what the next cycle must show.
    typedef enum {P_FREE, P_ARM, P_WAIT, P_SHOT, P_REST} phase_t;
    phase_t      m_ph;
    int unsigned m_ptr, m_own, m_waited, m_rest;
    bit          m_prev;
    logic [NUM_REQ-1:0] e_pulse;
    bit          e_gen, e_to;

    task automatic model_reset();
        m_ph = P_FREE; m_ptr = 0; m_own = 0; m_waited = 0; m_rest = 0; m_prev = 0;
        e_pulse = '0; e_gen = 0; e_to = 0;
    endtask

    task automatic model_edge();
        bit rise;
        bit found;
        int unsigned c;
        rise = pulse_in && !m_prev;
        e_gen = 0; e_to = 0; e_pulse = '0;
        case (m_ph)
            P_FREE: if (bus.req != '0) begin
                found = 0;
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (!found && bus.req[c]) begin found = 1; m_own = c; end
                end
                m_ph = P_ARM; e_gen = 1;
            end
            P_ARM: begin m_waited = 0; m_ph = P_WAIT; end
            P_WAIT: begin
                if (!bus.req[m_own]) begin
                    m_ptr = (m_own + 1) % NUM_REQ; m_ph = P_FREE;
                end else if (rise) begin
                    m_ph = P_SHOT; e_pulse[m_own] = 1'b1;
                end else if (m_waited == TIMEOUT - 1) begin
                    e_to = 1; m_ptr = (m_own + 1) % NUM_REQ;
                    m_rest = (holdoff == 0) ? 1 : int'(holdoff); m_ph = P_REST;
                end else m_waited++;
            end
            P_SHOT: begin
                m_ptr = (m_own + 1) % NUM_REQ;
                if (holdoff != 0) begin m_rest = holdoff; m_ph = P_REST; end
                else m_ph = P_FREE;
            end
            P_REST: begin m_rest--; if (m_rest == 0) m_ph = P_FREE; end
            default: m_ph = P_FREE;
        endcase
        m_prev = pulse_in;
    endtask

    int unsigned obs_gen, obs_pulse, obs_to, obs_hold, obs_wait;
    logic [NUM_REQ-1:0] last_pulse;

    task automatic clear_obs();
        obs_gen = 0; obs_pulse = 0; obs_to = 0; obs_hold = 0; obs_wait = 0; last_pulse = '0;
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] e_grant;
        model_edge();
        @(posedge clk); #1;
        e_grant = (m_ph inside {P_ARM, P_WAIT, P_SHOT}) ? (NUM_REQ'(1) << m_own) : '0;
        check("grant", bus.grant, e_grant);
        check("pulse_out", bus.pulse_out, e_pulse);
        check("gen_enable", gen_enable, e_gen);
        check("timeout", bus.timeout, e_to);
        check("busy", bus.busy, m_ph != P_FREE);
        if (gen_enable) obs_gen++;
        if (bus.pulse_out != '0) begin obs_pulse++; last_pulse = bus.pulse_out; end
        if (bus.timeout) obs_to++;
        if (bus.busy && bus.grant == '0) obs_hold++;
        if (bus.grant != '0 && !gen_enable && bus.pulse_out == '0) obs_wait++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, bus.grant, '0);
        check({tag, "_pulse"}, bus.pulse_out, '0);
        check({tag, "_gen"}, gen_enable, 1'b0);
        check({tag, "_to"}, bus.timeout, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("rst");
        model_reset();
        reset = 1'b0;
    endtask

    // Step until the first nonzero grant appears; returns it (0 if the bound expires).
    task automatic next_grant(output logic [NUM_REQ-1:0] g);
        g = '0;
        for (int i = 0; i < 40 && g == '0; i++) begin
            step();
            g = bus.grant;
        end
    endtask

    logic [NUM_REQ-1:0] seq [5];
    logic [NUM_REQ-1:0] g;
    int unsigned        nseq;

    initial begin
        bus.req = '0; holdoff = '0; pulse_in = 1'b0; reset = 1'b1;
        model_reset();
        do_reset();

        // Single requester, rise five cycles after ARM, two hold-off cycles.
        clear_obs();
        bus.req = 4'b0010; holdoff = 8'd2;
        step();
        check("s1_arm_grant", bus.grant, 4'b0010);
        check("s1_arm_gen", gen_enable, 1'b1);
        for (int i = 0; i < 4; i++) step();
        pulse_in = 1'b1;
        step();
        check("s1_pulse", bus.pulse_out, 4'b0010);
        bus.req = '0; pulse_in = 1'b0;
        for (int i = 0; i < 20 && bus.busy; i++) step();
        check("s1_gen_count", obs_gen, 1);
        check("s1_pulse_count", obs_pulse, 1);
        check("s1_hold_cycles", obs_hold, 2);
        check("s1_idle", bus.busy, 1'b0);

        // All requesting, zero hold-off, a rise available in every WAIT.
        do_reset();
        clear_obs();
        bus.req = 4'b1111; holdoff = '0; nseq = 0;
        for (int i = 0; i < 80 && nseq < 5; i++) begin
            pulse_in = ~pulse_in;
            step();
            if (bus.pulse_out != '0) begin seq[nseq] = bus.pulse_out; nseq++; end
        end
        check("s2_count", nseq, 5);
        check("s2_seq0", seq[0], 4'b0001);
        check("s2_seq1", seq[1], 4'b0010);
        check("s2_seq2", seq[2], 4'b0100);
        check("s2_seq3", seq[3], 4'b1000);
        check("s2_seq4", seq[4], 4'b0001);

        // Serve bit 2, then 0101 must wrap past bit 3 back to bit 0.
        bus.req = '0; pulse_in = 1'b0;
        do_reset();
        clear_obs();
        bus.req = 4'b0100;
        for (int i = 0; i < 40 && obs_pulse == 0; i++) begin
            pulse_in = ~pulse_in;
            step();
        end
        check("s3_served2", last_pulse, 4'b0100);
        bus.req = 4'b0101; pulse_in = 1'b0;
        next_grant(g);
        check("s3_wrap_grant", g, 4'b0001);

        // No rise for a whole WAIT window.
        bus.req = '0;
        do_reset();
        clear_obs();
        bus.req = 4'b0001; holdoff = 8'd1; pulse_in = 1'b0;
        for (int i = 0; i < TIMEOUT + 10 && obs_to == 0; i++) step();
        check("s4_timeout_seen", obs_to, 1);
        check("s4_wait_cycles", obs_wait, TIMEOUT);
        check("s4_no_pulse", obs_pulse, 0);
        bus.req = 4'b0011;
        next_grant(g);
        check("s4_next_grant", g, 4'b0010);

        // Withdraw the owner while it waits.
        step();
        bus.req = 4'b0001;
        step();
        check("s6_wd_grant", bus.grant, '0);
        check("s6_wd_busy", bus.busy, 1'b0);

        // Level already high at ARM, then a rise during HOLD.
        bus.req = '0;
        do_reset();
        clear_obs();
        pulse_in = 1'b1; holdoff = 8'd3;
        step();
        bus.req = 4'b0100;
        for (int i = 0; i < 12; i++) step();
        check("s5_no_level_pulse", obs_pulse, 0);
        pulse_in = 1'b0; step();
        pulse_in = 1'b1; step();
        check("s5_rise_pulse", bus.pulse_out, 4'b0100);
        bus.req = '0;
        step();
        pulse_in = 1'b0; step();
        pulse_in = 1'b1; step();
        for (int i = 0; i < 6; i++) step();
        check("s5_hold_rise_dropped", obs_pulse, 1);

        // Reset in the middle of WAIT clears outputs at once and rr_ptr back to 0.
        do_reset();
        clear_obs();
        pulse_in = 1'b0; holdoff = 8'd1;
        bus.req = 4'b0010;
        for (int i = 0; i < 30 && obs_pulse == 0; i++) begin
            pulse_in = ~pulse_in;
            step();
        end
        bus.req = 4'b0001; pulse_in = 1'b0;
        next_grant(g);
        check("s7_grant0", g, 4'b0001);
        step(); step(); step();
        check("s7_in_wait", bus.grant, 4'b0001);
        #3 reset = 1'b1;
        #1 check_idle_outputs("s7_async");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req = 4'b1111;
        next_grant(g);
        check("s7_ptr_zero", g, 4'b0001);

        // Randomized traffic against the model.
        holdoff = HOLDOFF_W'($urandom_range(1, 3));
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) bus.req = bus.req ^ (NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1));
            if ($urandom_range(0, 3) == 0) pulse_in = ~pulse_in;
            if ($urandom_range(0, 49) == 0) holdoff = HOLDOFF_W'($urandom_range(1, 3));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
